cpu_stack_unit: RTL

Parametrised data/return stack engine for the next-generation stack CPU. It holds TOS and NOS in registers, backed by a spill array of DEPTH-2 words, and executes one stack-shuffle opcode per clock. It generalises the fixed 32-bit × 256 stack with width, depth, bounds protection, sticky overflow/underflow flags and a high-water mark, replacing ad-hoc SP/RP readback for stack checking. Two instances are used per CPU: data stack and return stack.

---
 rtl/cpu_stack_unit.sv | 128 ++++++++++++
 1 files changed

// File: rtl/cpu_stack_unit.sv
// Parametrised stack engine: TOS/NOS in registers, deeper entries in a spill RAM.
// Executes one shuffle op per clock, with bounds checking, sticky error flags and a high-water mark.
module cpu_stack_unit #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 256,
    parameter int DW    = $clog2(DEPTH+1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] din,
    input  logic             clr_err,
    input  logic             clr_hwm,
    output logic [WIDTH-1:0] tos,
    output logic [WIDTH-1:0] nos,
    output logic [DW-1:0]    depth,
    output logic [DW-1:0]    hwm,
    output logic             ovf,
    output logic             unf,
    output logic             err
);
    localparam int MW = DEPTH - 2;
    localparam int AW = (MW > 1) ? $clog2(MW) : 1;

    localparam logic [3:0] OP_PUSH    = 4'd1;
    localparam logic [3:0] OP_DROP    = 4'd2;
    localparam logic [3:0] OP_DUP     = 4'd3;
    localparam logic [3:0] OP_SWAP    = 4'd4;
    localparam logic [3:0] OP_OVER    = 4'd5;
    localparam logic [3:0] OP_ROT     = 4'd6;
    localparam logic [3:0] OP_REDUCE  = 4'd7;
    localparam logic [3:0] OP_REPLACE = 4'd8;

    logic [WIDTH-1:0] mem [MW];
    logic [WIDTH-1:0] tos_r, nos_r, tos_nx, nos_nx, third, wd;
    logic [DW-1:0]    depth_r, depth_nx, hwm_r, need;
    logic [AW-1:0]    wa, a2, a3;
    logic             grow, shrink, we, bad_unf, bad_ovf, ok;
    logic             ovf_r, unf_r, err_r;

    // Entry at stack position i (0 = bottom) lives in mem[i]; c sits at depth-3.
    assign a2    = AW'(depth_r - DW'(2));
    assign a3    = AW'(depth_r - DW'(3));
    assign third = (depth_r >= DW'(3)) ? mem[a3] : '0;

    always_comb begin
        need   = '0;
        grow   = 1'b0;
        shrink = 1'b0;
        tos_nx = tos_r;
        nos_nx = nos_r;
        we     = 1'b0;
        wa     = a2;
        wd     = nos_r;
        case (op)
            OP_PUSH: begin
                grow = 1'b1; tos_nx = din; nos_nx = tos_r;
                we = (depth_r >= DW'(2));
            end
            OP_DROP: begin
                need = DW'(1); shrink = 1'b1; tos_nx = nos_r; nos_nx = third;
            end
            OP_DUP: begin
                need = DW'(1); grow = 1'b1; nos_nx = tos_r;
                we = (depth_r >= DW'(2));
            end
            OP_SWAP: begin
                need = DW'(2); tos_nx = nos_r; nos_nx = tos_r;
            end
            OP_OVER: begin
                need = DW'(2); grow = 1'b1; tos_nx = nos_r; nos_nx = tos_r; we = 1'b1;
            end
            OP_ROT: begin
                need = DW'(3); tos_nx = third; nos_nx = tos_r; we = 1'b1; wa = a3;
            end
            OP_REDUCE: begin
                need = DW'(2); shrink = 1'b1; tos_nx = din; nos_nx = third;
            end
            OP_REPLACE: begin
                need = DW'(1); tos_nx = din;
            end
            default: ;
        endcase
        // Underflow and overflow ranges are disjoint, so at most one fires.
        bad_unf  = (depth_r < need);
        bad_ovf  = grow && (depth_r == DW'(DEPTH));
        ok       = !bad_unf && !bad_ovf;
        depth_nx = depth_r;
        if (ok && grow)   depth_nx = depth_r + DW'(1);
        if (ok && shrink) depth_nx = depth_r - DW'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst && ok && we) mem[wa] <= wd;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tos_r   <= '0;
            nos_r   <= '0;
            depth_r <= '0;
            hwm_r   <= '0;
            ovf_r   <= 1'b0;
            unf_r   <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            if (ok) begin
                tos_r   <= tos_nx;
                nos_r   <= nos_nx;
                depth_r <= depth_nx;
            end
            if (clr_hwm)              hwm_r <= depth_nx;
            else if (depth_nx > hwm_r) hwm_r <= depth_nx;
            // Set beats clear when both land in the same cycle.
            ovf_r <= bad_ovf | (ovf_r & ~clr_err);
            unf_r <= bad_unf | (unf_r & ~clr_err);
            err_r <= bad_ovf | bad_unf;
        end
    end

    assign tos   = (depth_r != '0)       ? tos_r : '0;
    assign nos   = (depth_r >= DW'(2))   ? nos_r : '0;
    assign depth = depth_r;
    assign hwm   = hwm_r;
    assign ovf   = ovf_r;
    assign unf   = unf_r;
    assign err   = err_r;
endmodule
